// File: rtl/enc_vlc_pkg.sv
// Shared codebook table and sign-bit polarity for the AC level VLC encoder.
package enc_vlc_pkg;

   typedef struct packed {
      logic [1:0] lim;   // Rice/escape limit L
      logic [1:0] k;     // Exp-Golomb order of the escape suffix
   } codebook_t;

   localparam logic SIGN_NEG = 1'b1;

   // cls is prev saturated to 8, so every prev >= 8 lands in the last class.
   function automatic codebook_t codebook_lookup(input logic [3:0] cls);
      codebook_t cb;
      if (cls == 4'd0)      cb = '{lim: 2'd3, k: 2'd2};
      else if (cls == 4'd1) cb = '{lim: 2'd2, k: 2'd1};
      else if (cls == 4'd2) cb = '{lim: 2'd3, k: 2'd1};
      else if (cls == 4'd3) cb = '{lim: 2'd0, k: 2'd0};
      else if (cls < 4'd8)  cb = '{lim: 2'd0, k: 2'd1};
      else                  cb = '{lim: 2'd0, k: 2'd2};
      return cb;
   endfunction

endpackage

// File: rtl/ac_level_codeword.sv
// Codeword builder: (val, L, k, sign) -> right-justified code, length, overflow flag.
module ac_level_codeword
   import enc_vlc_pkg::*;
#(
   parameter int COEFF_W = 20,
   parameter int CODE_W  = 32,
   parameter int LEN_W   = $clog2(CODE_W + 1)
) (
   input  logic [COEFF_W-2:0] val,
   input  codebook_t          cb,
   input  logic               sign,
   output logic [CODE_W-1:0]  code,
   output logic [LEN_W-1:0]   len,
   output logic               err
);
   localparam int VW = COEFF_W - 1;
   localparam int MW = COEFF_W + 1;
   localparam int TW = 8;

   logic          rice;
   logic [MW-1:0] m;
   logic [TW-1:0] b;
   logic [TW-1:0] tot;
   logic [MW:0]   cw;

   // Leading zeros carry no value, so the code is just {1, sign} or {m, sign}.
   always_comb begin
      rice = val < VW'(cb.lim);
      m    = MW'(val) - MW'(cb.lim) + (MW'(1) << cb.k);
      b    = '0;
      for (int i = 0; i < MW; i++) begin
         if (m[i]) b = TW'(i);
      end
      if (rice) begin
         tot = TW'(val) + TW'(2);
         cw  = (MW + 1)'({1'b1, sign});
      end else begin
         tot = TW'(cb.lim) + (b << 1) - TW'(cb.k) + TW'(2);
         cw  = {m, sign};
      end
      err  = tot > TW'(CODE_W);
      code = err ? '0 : CODE_W'(cw);
      len  = err ? '0 : LEN_W'(tot);
   end

endmodule

// File: rtl/ac_level_vlc_encoder.sv
// Two-stage AC level VLC encoder (S1: val/codebook, S2: codeword register).
// Optional AC_LEVEL_BITCOUNT_EN adds the per-block bit counter blk_bits.
module ac_level_vlc_encoder
   import enc_vlc_pkg::*;
#(
   parameter int COEFF_W = 20,
   parameter int CODE_W  = 32,
   parameter int LEN_W   = $clog2(CODE_W + 1)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic signed [COEFF_W-1:0] in_coeff,
   input  logic                      in_sob,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [CODE_W-1:0]         out_code,
   output logic [LEN_W-1:0]          out_len,
   output logic                      out_err
`ifdef AC_LEVEL_BITCOUNT_EN
   ,
   output logic [23:0]               blk_bits
`endif
);
   localparam int VW = COEFF_W - 1;

   logic [VW-1:0]      prev_reg;
   logic               s1_full_reg;
   logic [VW-1:0]      s1_val_reg;
   logic               s1_sign_reg;
   codebook_t          s1_cb_reg;
   logic               s2_full_reg;
   logic [CODE_W-1:0]  out_code_reg;
   logic [LEN_W-1:0]   out_len_reg;
   logic               out_err_reg;

   logic [COEFF_W-1:0] coeff_u;
   logic [COEFF_W-1:0] mag;
   logic [VW-1:0]      in_val;
   logic               in_neg;
   logic [VW-1:0]      prev_eff;
   logic [3:0]         cls;
   logic               s2_can;
   logic               accept;
   logic               load_s1;
   logic [CODE_W-1:0]  cw_code;
   logic [LEN_W-1:0]   cw_len;
   logic               cw_err;

   // The most-negative input wraps to 2^(COEFF_W-1), so val = mag-1 still fits VW bits.
   always_comb begin
      coeff_u  = in_coeff;
      in_neg   = in_coeff[COEFF_W-1];
      mag      = in_neg ? (~coeff_u + COEFF_W'(1)) : coeff_u;
      in_val   = VW'(mag - COEFF_W'(1));
      prev_eff = in_sob ? VW'(1) : prev_reg;
      cls      = (prev_eff >= VW'(8)) ? 4'd8 : prev_eff[3:0];
   end

   assign s2_can    = !s2_full_reg || out_ready;
   assign in_ready  = !reset && (!s1_full_reg || s2_can);
   assign accept    = in_valid && in_ready;
   assign load_s1   = accept && (in_coeff != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_reg     <= VW'(1);
         s1_full_reg  <= 1'b0;
         s1_val_reg   <= '0;
         s1_sign_reg  <= 1'b0;
         s1_cb_reg    <= '0;
         s2_full_reg  <= 1'b0;
         out_code_reg <= '0;
         out_len_reg  <= '0;
         out_err_reg  <= 1'b0;
      end else begin
         if (load_s1)
            prev_reg <= in_val;
         else if (accept && in_sob)
            prev_reg <= VW'(1);

         if (load_s1) begin
            s1_full_reg <= 1'b1;
            s1_val_reg  <= in_val;
            s1_sign_reg <= in_neg ? SIGN_NEG : ~SIGN_NEG;
            s1_cb_reg   <= codebook_lookup(cls);
         end else if (s2_can) begin
            s1_full_reg <= 1'b0;
         end

         if (s1_full_reg && s2_can) begin
            s2_full_reg  <= 1'b1;
            out_code_reg <= cw_code;
            out_len_reg  <= cw_len;
            out_err_reg  <= cw_err;
         end else if (out_ready) begin
            s2_full_reg <= 1'b0;
         end
      end
   end

   ac_level_codeword #(
      .COEFF_W (COEFF_W),
      .CODE_W  (CODE_W),
      .LEN_W   (LEN_W)
   ) u_codeword (
      .val  (s1_val_reg),
      .cb   (s1_cb_reg),
      .sign (s1_sign_reg),
      .code (cw_code),
      .len  (cw_len),
      .err  (cw_err)
   );

   assign out_valid = s2_full_reg;
   assign out_code  = out_code_reg;
   assign out_len   = out_len_reg;
   assign out_err   = out_err_reg;

`ifdef AC_LEVEL_BITCOUNT_EN
   logic        s1_sob_reg;
   logic        s2_sob_reg;
   logic [23:0] blk_bits_reg;
   logic [24:0] blk_sum;

   assign blk_sum = {1'b0, blk_bits_reg} + 25'(out_len_reg);

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_sob_reg   <= 1'b0;
         s2_sob_reg   <= 1'b0;
         blk_bits_reg <= '0;
      end else begin
         if (load_s1)
            s1_sob_reg <= in_sob;
         if (s1_full_reg && s2_can)
            s2_sob_reg <= s1_sob_reg;
         if (s2_full_reg && out_ready) begin
            if (s2_sob_reg)
               blk_bits_reg <= 24'(out_len_reg);
            else if (blk_sum[24])
               blk_bits_reg <= '1;
            else
               blk_bits_reg <= blk_sum[23:0];
         end
      end
   end

   assign blk_bits = blk_bits_reg;
`endif

endmodule

// File: tb/tb_ac_level_vlc_encoder.sv
// Randomised and directed bench for ac_level_vlc_encoder with a bit-level reference model.
module tb_ac_level_vlc_encoder;
   localparam int COEFF_W = 20;
   localparam int CODE_W  = 32;
   localparam int LEN_W   = $clog2(CODE_W + 1);

   logic                      clk = 1'b0;
   logic                      reset = 1'b1;
   logic                      in_valid = 1'b0;
   logic                      in_sob = 1'b0;
   logic                      out_ready = 1'b1;
   logic signed [COEFF_W-1:0] in_coeff = '0;
   logic                      in_ready;
   logic                      out_valid;
   logic                      out_err;
   logic [CODE_W-1:0]         out_code;
   logic [LEN_W-1:0]          out_len;

   ac_level_vlc_encoder #(.COEFF_W(COEFF_W), .CODE_W(CODE_W), .LEN_W(LEN_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_coeff  (in_coeff),
      .in_sob    (in_sob),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_code  (out_code),
      .out_len   (out_len),
      .out_err   (out_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      longint unsigned code;
      int              len;
      bit              err;
   } cw_t;

   int     n_tests = 0;
   int     n_fail = 0;
   int     n_out = 0;
   cw_t    sb_q[$];
   cw_t    lit_q[$];
   longint prev_m = 1;

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Builds the codeword bit by bit, exactly as the code is defined.
   function automatic cw_t model_encode(input longint coeff, input longint prev, output longint val);
      cw_t    r;
      int     lim, k, b;
      longint n, m;
      val = ((coeff < 0) ? -coeff : coeff) - 1;
      if (prev == 0)      begin lim = 3; k = 2; end
      else if (prev == 1) begin lim = 2; k = 1; end
      else if (prev == 2) begin lim = 3; k = 1; end
      else if (prev == 3) begin lim = 0; k = 0; end
      else if (prev <= 7) begin lim = 0; k = 1; end
      else                begin lim = 0; k = 2; end
      r.code = 0; r.len = 0; r.err = 0;
      if (val < lim) begin
         for (longint i = 0; i < val; i++) begin r.code = r.code << 1; r.len++; end
         r.code = (r.code << 1) | 1; r.len++;
      end else begin
         n = val - lim;
         m = n + (longint'(1) << k);
         b = 0;
         while ((longint'(1) << (b + 1)) <= m) b++;
         for (int i = 0; i < lim + b - k; i++) begin r.code = r.code << 1; r.len++; end
         for (int i = b; i >= 0; i--) begin r.code = (r.code << 1) | ((m >> i) & 1); r.len++; end
      end
      r.code = (r.code << 1) | ((coeff < 0) ? 1 : 0);
      r.len++;
      if (r.len > CODE_W) begin r.err = 1; r.code = 0; r.len = 0; end
      return r;
   endfunction

   // Monitor: one pass per cycle, away from the active edge.
   cw_t               mon_e;
   longint            mon_v;
   bit                stall = 0;
   bit                rst_d = 0;
   logic [CODE_W-1:0] st_code;
   logic [LEN_W-1:0]  st_len;
   logic              st_err;

   always @(negedge clk) begin
      if (reset) begin
         check("in_ready_during_reset", in_ready, 0);
         sb_q.delete();
         lit_q.delete();
         prev_m = 1;
         stall  = 0;
         rst_d  = 1;
      end else begin
         if (rst_d) check("out_valid_after_reset", out_valid, 0);
         rst_d = 0;
         check("in_ready", in_ready, (sb_q.size() < 2 || out_ready) ? 1 : 0);
         if (stall) begin
            check("hold_valid", out_valid, 1);
            check("hold_code", out_code, st_code);
            check("hold_len", out_len, st_len);
            check("hold_err", out_err, st_err);
         end
         if (out_valid && out_ready) begin
            n_out++;
            if (sb_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_output: got code %0h len %0d, expected no output", out_code, out_len);
            end else begin
               mon_e = sb_q.pop_front();
               check("code", out_code, mon_e.code);
               check("len", out_len, mon_e.len);
               check("err", out_err, mon_e.err);
            end
            if (lit_q.size() > 0) begin
               mon_e = lit_q.pop_front();
               check("lit_code", out_code, mon_e.code);
               check("lit_len", out_len, mon_e.len);
               check("lit_err", out_err, mon_e.err);
            end
         end
         if (in_valid && in_ready) begin
            if (in_sob) prev_m = 1;
            if (in_coeff != 0) begin
               mon_e = model_encode(in_coeff, prev_m, mon_v);
               sb_q.push_back(mon_e);
               prev_m = mon_v;
            end
         end
         stall   = out_valid && !out_ready;
         st_code = out_code;
         st_len  = out_len;
         st_err  = out_err;
      end
   end

   task automatic idle(input int n);
      in_valid = 1'b0;
      in_sob   = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // Entered at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic send(input int c, input bit sob);
      bit acc;
      acc      = 1'b0;
      in_valid = 1'b1;
      in_coeff = COEFF_W'(c);
      in_sob   = sob;
      for (int t = 0; t < 50 && !acc; t++) begin
         #1;
         acc = in_ready;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_sob   = 1'b0;
      if (!acc) begin
         n_tests++;
         n_fail++;
         $display("FAIL send_timeout: got in_ready 0 for 50 cycles, expected acceptance of %0d", c);
      end
   endtask

   function automatic cw_t lit(input longint unsigned code, input int len, input bit err);
      cw_t r;
      r.code = code; r.len = len; r.err = err;
      return r;
   endfunction

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish, expected finish before 2 ms");
      $fatal(1, "timeout");
   end

   initial begin
      cw_t    p;
      longint v;
      int     lat, n0, acc_cnt, k, c, r;

      // Pin the model against hand-derived codewords.
      p = model_encode(1, 1, v);       check("pin_p1_code", p.code, 2);  check("pin_p1_len", p.len, 2);
      p = model_encode(-3, 0, v);      check("pin_m3_code", p.code, 3);  check("pin_m3_len", p.len, 4);
      p = model_encode(5, 2, v);       check("pin_p5_code", p.code, 6);  check("pin_p5_len", p.len, 6);
      p = model_encode(10, 1, v);      check("pin_p10_code", p.code, 18); check("pin_p10_len", p.len, 9);
      p = model_encode(524287, 9, v);  check("pin_big_err", p.err, 1);   check("pin_big_len", p.len, 0);

      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check("in_ready_after_reset", in_ready, 1);

      // sob +1, then -3, +5 with latency check.
      lit_q.push_back(lit(2, 2, 0));
      lit_q.push_back(lit(3, 4, 0));
      lit_q.push_back(lit(6, 6, 0));
      send(1, 1);
      lat = 1;
      while (!out_valid && lat < 10) begin @(posedge clk); #1; lat++; end
      check("latency", lat, 2);
      send(-3, 0);
      send(5, 0);
      idle(6);

      // A zero coefficient is dropped and leaves prev alone.
      n0 = n_out;
      lit_q.push_back(lit(2, 2, 0));
      lit_q.push_back(lit(3, 2, 0));
      send(1, 1);
      send(0, 0);
      send(-1, 0);
      idle(6);
      check("zero_drop_count", n_out - n0, 2);

      // Output stalled for 6 cycles with input always offered.
      out_ready = 1'b0;
      acc_cnt   = 0;
      k         = 1;
      in_valid  = 1'b1;
      in_sob    = 1'b1;
      in_coeff  = COEFF_W'(k);
      repeat (6) begin
         #1;
         if (in_ready) begin acc_cnt++; k++; in_sob = 1'b0; end
         @(posedge clk); #1;
         in_coeff = COEFF_W'(k);
      end
      check("stall_accepts", acc_cnt, 2);
      out_ready = 1'b1;
      repeat (4) begin
         #1;
         if (in_ready) k++;
         @(posedge clk); #1;
         in_coeff = COEFF_W'(k);
      end
      idle(6);

      // prev >= 8, then an overlong codeword.
      lit_q.push_back(lit(18, 9, 0));
      lit_q.push_back(lit(0, 0, 1));
      send(10, 1);
      send(524287, 0);
      idle(6);

      // Reset with both stages full.
      out_ready = 1'b0;
      send(3, 1);
      send(4, 0);
      #1;
      check("full_in_ready", in_ready, 0);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("reset_full_out_valid", out_valid, 0);
      out_ready = 1'b1;
      #1;
      check("reset_full_in_ready", in_ready, 1);
      lit_q.push_back(lit(2, 2, 0));
      send(1, 1);
      idle(6);

      // Randomised traffic with random stalls and rare resets.
      repeat (3000) begin
         r = int'($urandom_range(0, 15));
         if (r <= 11)      c = int'($urandom_range(0, 18)) - 9;
         else if (r <= 13) c = int'($urandom_range(0, 600)) - 300;
         else if (r == 14) c = int'($urandom_range(0, 1048575)) - 524288;
         else              c = ($urandom_range(0, 1) != 0) ? 524287 : -524288;
         in_coeff  = COEFF_W'(c);
         in_valid  = ($urandom_range(0, 3) != 0);
         in_sob    = ($urandom_range(0, 7) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
         reset     = ($urandom_range(0, 599) == 0);
         @(posedge clk); #1;
      end
      reset     = 1'b0;
      out_ready = 1'b1;
      idle(8);
      check("drain_empty", sb_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ac_level_vlc_encoder.md
AC_LEVEL_VLC_ENCODER -- requirements
Module: ac_level_vlc_encoder

Interface
REQ-001 SHALL have parameter COEFF_W, default 20, signed coefficient width (range 8..24).
REQ-002 SHALL have parameter CODE_W, default 32, maximum codeword width in bits (range 16..64).
REQ-003 SHALL have parameter LEN_W, default $clog2(CODE_W+1), width of the length field.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  coefficient present.
REQ-007 SHALL have port in_ready  output  1  encoder accepts in_coeff this cycle.
REQ-008 SHALL have port in_coeff  input  COEFF_W  signed nonzero AC coefficient.
REQ-009 SHALL have port in_sob  input  1  first coefficient of a block; qualified by in_valid.
REQ-010 SHALL have port out_valid  output  1  codeword present.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the codeword.
REQ-012 SHALL have port out_code  output  CODE_W  codeword, right-justified, MSB-first.
REQ-013 SHALL have port out_len  output  LEN_W  valid bit count of out_code.
REQ-014 SHALL have port out_err  output  1  codeword exceeded CODE_W.

Function
REQ-015 SHALL accept an input on in_valid && in_ready; out_valid && out_ready consumes an output.
REQ-016 SHALL form val = |in_coeff| - 1 and sign = in_coeff < 0; the most-negative code is encoded with val = 2^(COEFF_W-1) - 1.
REQ-017 SHALL select the codebook from prev: prev 0 -> limit L=3, k=2; prev 1 -> L=2, k=1; prev 2 -> L=3, k=1; prev 3 -> L=0, k=0; prev 4..7 -> L=0, k=1; prev >= 8 -> L=0, k=2.
REQ-018 SHALL emit Rice when val < L: val zeros, then one 1.
REQ-019 SHALL emit escape when val >= L: L zeros, then Exp-Golomb order k of n = val - L.
REQ-020 SHALL build the order-k Exp-Golomb code as follows: m = n + 2^k, b = floor(log2 m); emit (b-k) zeros, then m in b+1 bits.
REQ-021 SHALL append one sign bit as LSB: 1 = negative.
REQ-022 SHALL set out_len to the total length including the sign bit.
REQ-023 SHALL set prev to 1 at reset and when an in_sob input is accepted (before codebook selection); after every encoded input, prev takes that input's val.
REQ-024 SHALL silently drop an accepted in_coeff == 0: no output, prev unchanged.
REQ-025 SHALL run as a 2-stage pipeline (S1 codebook/val, S2 codeword), giving latency 2 cycles from acceptance to out_valid when out_ready is held high; throughput is 1 per cycle.
REQ-026 SHALL advance each stage when it is empty or the next stage advances; in_ready = !S1_full || S1_advances, combinational from out_ready, with no loss, duplication or reordering under any stall pattern.
REQ-027 SHALL hold out_code, out_len and out_err stable while out_valid && !out_ready.
REQ-028 SHALL, when the total length > CODE_W, set out_err = 1, out_len = 0, out_code = 0, and still update prev.

Reset
REQ-029 SHALL clear out_valid, out_code, out_len, out_err and both stages and set prev = 1 while reset is high; in-flight data is discarded.
REQ-030 SHALL drive in_ready = 0 during reset and 1 in the first cycle after reset.

Configuration
REQ-031 SHALL, with AC_LEVEL_BITCOUNT_EN defined, add output blk_bits [23:0]: the sum of out_len over delivered codewords since the last sob, saturating at 2^24-1.
REQ-032 SHALL clear blk_bits to 0 at reset and set it to that codeword's length when an sob codeword is delivered.
REQ-033 SHALL, without AC_LEVEL_BITCOUNT_EN, have no blk_bits port and no counter logic; the other behaviour is identical.

Structure
REQ-034 SHALL place the codebook table (L, k per prev class) and the sign-bit polarity constant in shared package enc_vlc_pkg.
REQ-035 SHALL implement the codeword builder (val, L, k, sign -> code, len, err) as sub-module ac_level_codeword, instantiated in S2.

Verification
REQ-036 SHALL test reset, then sob with coeff +1 -> out_code 0b10, out_len 2, out_valid 2 cycles later.
REQ-037 SHALL test that stream, next coeff -3 (prev 0) -> out_code 0b0011, out_len 4; next coeff +5 (prev 2) -> out_code 0b000110, out_len 6.
REQ-038 SHALL test coeffs 1, 0, -1 -> exactly two outputs; the third uses prev 0 -> 0b11, len 2.
REQ-039 SHALL test out_ready low 6 cycles with in_valid continuously high -> in_ready drops after 2 accepts, outputs resume in order without loss when out_ready rises.
REQ-040 SHALL test prev >= 8, then coeff 524287 at COEFF_W 20, CODE_W 32 -> length 38, out_err 1, out_len 0.
REQ-041 SHALL test reset asserted with both stages full -> out_valid 0 next cycle; the next sob coeff +1 -> 0b10.
